ex_wb_pipe: RTL and testbench



---
 rtl/ex_wb_pipe.sv | 143 ++++++++++++++
 tb/tb_ex_wb_pipe.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ex_wb_pipe.sv
// EX->WB pipeline register with valid/ready handshake, two-entry skid buffer,
// synchronous flush and a forwarding tap exposing the newest pending register write.
module ex_wb_pipe #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int OP_W   = 2
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   opcodeIn,
    input  logic [DATA_W-1:0] WriteDataIn,
    input  logic              WriteSignalIn,
    input  logic [REG_AW-1:0] WriteRegisterIn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   opcodeOut,
    output logic [DATA_W-1:0] WriteDataOut,
    output logic              WriteSignalOut,
    output logic [REG_AW-1:0] WriteRegisterOut,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic [1:0]        count
);

    logic              main_valid_q, main_valid_d;
    logic [OP_W-1:0]   main_op_q,    main_op_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              main_wsig_q,  main_wsig_d;
    logic [REG_AW-1:0] main_reg_q,   main_reg_d;

    logic              skid_valid_q, skid_valid_d;
    logic [OP_W-1:0]   skid_op_q,    skid_op_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              skid_wsig_q,  skid_wsig_d;
    logic [REG_AW-1:0] skid_reg_q,   skid_reg_d;

    logic in_fire;
    logic out_fire;

    // Ready depends only on held state and Reset, so no comb path from out_ready.
    assign in_ready  = ~skid_valid_q & ~Reset;
    assign out_valid = main_valid_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_op_d    = main_op_q;
        main_data_d  = main_data_q;
        main_wsig_d  = main_wsig_q;
        main_reg_d   = main_reg_q;
        skid_valid_d = skid_valid_q;
        skid_op_d    = skid_op_q;
        skid_data_d  = skid_data_q;
        skid_wsig_d  = skid_wsig_q;
        skid_reg_d   = skid_reg_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // Skid is always younger than main, so it refills main on drain.
            if (out_fire) begin
                main_valid_d = 1'b1;
                main_op_d    = skid_op_q;
                main_data_d  = skid_data_q;
                main_wsig_d  = skid_wsig_q;
                main_reg_d   = skid_reg_q;
                skid_valid_d = 1'b0;
            end
        end else if (!main_valid_q || out_ready) begin
            if (in_fire) begin
                main_valid_d = 1'b1;
                main_op_d    = opcodeIn;
                main_data_d  = WriteDataIn;
                main_wsig_d  = WriteSignalIn;
                main_reg_d   = WriteRegisterIn;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_op_d    = opcodeIn;
            skid_data_d  = WriteDataIn;
            skid_wsig_d  = WriteSignalIn;
            skid_reg_d   = WriteRegisterIn;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            main_valid_q <= 1'b0;
            main_op_q    <= '0;
            main_data_q  <= '0;
            main_wsig_q  <= 1'b0;
            main_reg_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_op_q    <= '0;
            skid_data_q  <= '0;
            skid_wsig_q  <= 1'b0;
            skid_reg_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_op_q    <= main_op_d;
            main_data_q  <= main_data_d;
            main_wsig_q  <= main_wsig_d;
            main_reg_q   <= main_reg_d;
            skid_valid_q <= skid_valid_d;
            skid_op_q    <= skid_op_d;
            skid_data_q  <= skid_data_d;
            skid_wsig_q  <= skid_wsig_d;
            skid_reg_q   <= skid_reg_d;
        end
    end

    assign opcodeOut        = main_op_q;
    assign WriteDataOut     = main_data_q;
    assign WriteSignalOut   = main_wsig_q & main_valid_q;
    assign WriteRegisterOut = main_reg_q;

    // Newest pending write wins: the skid entry is younger than main.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_reg   = '0;
        fwd_data  = '0;
        if (skid_valid_q && skid_wsig_q) begin
            fwd_valid = 1'b1;
            fwd_reg   = skid_reg_q;
            fwd_data  = skid_data_q;
        end else if (main_valid_q && main_wsig_q) begin
            fwd_valid = 1'b1;
            fwd_reg   = main_reg_q;
            fwd_data  = main_data_q;
        end
    end

    assign count = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_ex_wb_pipe.sv
// Directed-vector bench for ex_wb_pipe: streaming, back-pressure, forwarding, flush, reset.
module tb_ex_wb_pipe;

    logic       clk = 1'b0;
    logic       Reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0] opcodeIn, opcodeOut;
    logic [7:0] WriteDataIn, WriteDataOut;
    logic       WriteSignalIn, WriteSignalOut;
    logic [2:0] WriteRegisterIn, WriteRegisterOut;
    logic       fwd_valid;
    logic [2:0] fwd_reg;
    logic [7:0] fwd_data;
    logic [1:0] count;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    ex_wb_pipe #(.DATA_W(8), .REG_AW(3), .OP_W(2)) dut (
        .clk(clk), .Reset(Reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcodeIn(opcodeIn), .WriteDataIn(WriteDataIn),
        .WriteSignalIn(WriteSignalIn), .WriteRegisterIn(WriteRegisterIn),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcodeOut(opcodeOut), .WriteDataOut(WriteDataOut),
        .WriteSignalOut(WriteSignalOut), .WriteRegisterOut(WriteRegisterOut),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
        .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] d,
                         input logic w, input logic [2:0] r);
        in_valid        = v;
        opcodeIn        = op;
        WriteDataIn     = d;
        WriteSignalIn   = w;
        WriteRegisterIn = r;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] op,
                           input logic [7:0] d, input logic w, input logic [2:0] r);
        chk({tag, ".valid"}, out_valid, v);
        chk({tag, ".op"}, opcodeOut, op);
        chk({tag, ".data"}, WriteDataOut, d);
        chk({tag, ".wsig"}, WriteSignalOut, w);
        chk({tag, ".reg"}, WriteRegisterOut, r);
    endtask

    initial begin
        Reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 1'b0, 3'd0);
        tick();
        tick();
        chk_out("rst", 1'b0, 2'd0, 8'h00, 1'b0, 3'd0);
        chk("rst.in_ready", in_ready, 1'b0);
        chk("rst.fwd_valid", fwd_valid, 1'b0);
        chk("rst.fwd_reg", fwd_reg, 3'd0);
        chk("rst.fwd_data", fwd_data, 8'h00);
        chk("rst.count", count, 2'd0);
        Reset = 1'b0;
        #1;
        chk("post_rst.in_ready", in_ready, 1'b1);

        // Full-rate stream with out_ready high
        out_ready = 1'b1;
        drive(1'b1, 2'd1, 8'h11, 1'b1, 3'd2); tick();
        chk_out("strA", 1'b1, 2'd1, 8'h11, 1'b1, 3'd2);
        chk("strA.count", count, 2'd1);
        chk("strA.in_ready", in_ready, 1'b1);
        drive(1'b1, 2'd2, 8'h22, 1'b1, 3'd3); tick();
        chk_out("strB", 1'b1, 2'd2, 8'h22, 1'b1, 3'd3);
        chk("strB.count", count, 2'd1);
        chk("strB.in_ready", in_ready, 1'b1);
        drive(1'b1, 2'd3, 8'h33, 1'b1, 3'd4); tick();
        chk_out("strC", 1'b1, 2'd3, 8'h33, 1'b1, 3'd4);
        chk("strC.count", count, 2'd1);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 3'd0); tick();
        chk("drain.valid", out_valid, 1'b0);
        chk("drain.wsig", WriteSignalOut, 1'b0);
        chk("drain.count", count, 2'd0);

        // Back-pressure fills the skid
        drive(1'b1, 2'd1, 8'h11, 1'b1, 3'd2); tick();
        chk_out("bpA", 1'b1, 2'd1, 8'h11, 1'b1, 3'd2);
        out_ready = 1'b0;
        drive(1'b1, 2'd2, 8'h22, 1'b1, 3'd3); tick();
        chk_out("bpHold", 1'b1, 2'd1, 8'h11, 1'b1, 3'd2);
        chk("bpHold.count", count, 2'd2);
        chk("bpHold.in_ready", in_ready, 1'b0);
        chk("bpHold.fwd_reg", fwd_reg, 3'd3);
        chk("bpHold.fwd_data", fwd_data, 8'h22);
        drive(1'b1, 2'd3, 8'h44, 1'b1, 3'd6);
        tick();
        chk_out("bpStall", 1'b1, 2'd1, 8'h11, 1'b1, 3'd2);
        chk("bpStall.count", count, 2'd2);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 3'd0);
        out_ready = 1'b1; tick();
        chk_out("bpB", 1'b1, 2'd2, 8'h22, 1'b1, 3'd3);
        chk("bpB.count", count, 2'd1);
        chk("bpB.in_ready", in_ready, 1'b1);
        tick();
        chk("bpEnd.valid", out_valid, 1'b0);
        chk("bpEnd.count", count, 2'd0);

        // Forwarding priority, then flush with two entries held
        out_ready = 1'b0;
        drive(1'b1, 2'd1, 8'h11, 1'b1, 3'd2); tick();
        chk("fwdM.valid", fwd_valid, 1'b1);
        chk("fwdM.reg", fwd_reg, 3'd2);
        chk("fwdM.data", fwd_data, 8'h11);
        drive(1'b1, 2'd0, 8'h55, 1'b1, 3'd5); tick();
        chk("fwdS.reg", fwd_reg, 3'd5);
        chk("fwdS.data", fwd_data, 8'h55);
        chk("fwdS.count", count, 2'd2);
        flush = 1'b1;
        drive(1'b1, 2'd3, 8'h77, 1'b1, 3'd7); tick();
        chk("fl2.count", count, 2'd0);
        chk("fl2.valid", out_valid, 1'b0);
        chk("fl2.fwd_valid", fwd_valid, 1'b0);
        chk("fl2.fwd_reg", fwd_reg, 3'd0);
        flush = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 1'b0, 3'd0); tick();
        chk("fl2after.valid", out_valid, 1'b0);
        chk("fl2after.count", count, 2'd0);

        // Skid without a write: forwarding falls back to main
        drive(1'b1, 2'd1, 8'h11, 1'b1, 3'd2); tick();
        drive(1'b1, 2'd2, 8'h55, 1'b0, 3'd5); tick();
        chk("fwdSw0.valid", fwd_valid, 1'b1);
        chk("fwdSw0.reg", fwd_reg, 3'd2);
        chk("fwdSw0.data", fwd_data, 8'h11);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 3'd0);
        out_ready = 1'b1; tick();
        chk_out("w0main", 1'b1, 2'd2, 8'h55, 1'b0, 3'd5);
        chk("w0main.fwd_valid", fwd_valid, 1'b0);

        // Flush with in_ready high drops the presented input
        out_ready = 1'b0;
        flush = 1'b1;
        drive(1'b1, 2'd1, 8'h99, 1'b1, 3'd1);
        #1;
        chk("fl1.in_ready", in_ready, 1'b1);
        tick();
        chk("fl1.count", count, 2'd0);
        chk("fl1.valid", out_valid, 1'b0);
        flush = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 1'b0, 3'd0); tick();
        chk("fl1after.valid", out_valid, 1'b0);

        // Reset mid-stream
        out_ready = 1'b1;
        drive(1'b1, 2'd1, 8'h11, 1'b1, 3'd2); tick();
        chk("rmA.valid", out_valid, 1'b1);
        drive(1'b1, 2'd2, 8'h22, 1'b1, 3'd3);
        Reset = 1'b1;
        #1;
        chk("rm.in_ready", in_ready, 1'b0);
        tick();
        chk_out("rm", 1'b0, 2'd0, 8'h00, 1'b0, 3'd0);
        chk("rm.count", count, 2'd0);
        chk("rm.fwd_valid", fwd_valid, 1'b0);
        chk("rm.fwd_data", fwd_data, 8'h00);
        Reset = 1'b0;
        drive(1'b1, 2'd3, 8'h33, 1'b1, 3'd4); tick();
        chk_out("rmC", 1'b1, 2'd3, 8'h33, 1'b1, 3'd4);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 3'd0); tick();
        chk("rmEnd.valid", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
